// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - iterative RV32M multiply/divide unit (radix-2, one bit per cycle)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high
//   Start   in   launch an op; accepted only in IDLE or DONE
//   Funct3  in   M-extension funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   SrcA    in   rs1 (multiplicand / dividend)
//   SrcB    in   rs2 (multiplier / divisor)
//   Flush   in   abort an in-flight op without a Done pulse
//   Busy    out  high in CALC and FIX; the hazard unit stalls EX on it
//   Done    out  one-cycle pulse; Result valid in that cycle
//   Result  out  selected product half / quotient / remainder, held until next Done
module rv_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t state, state_n;

    logic [2:0]    op_q;
    logic [W-1:0]  opnd_q;      // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [W-1:0]  hi_q;        // product high half (mul) or partial remainder (div)
    logic [W-1:0]  lo_q;        // multiplier shifting out (mul) or dividend out / quotient in (div)
    logic          neg_q;       // product / quotient sign
    logic          rneg_q;      // remainder sign follows the dividend
    logic [CW-1:0] count;

    // Operand decode at the Start edge
    logic         is_div, a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         div_zero, div_ovf, special, accept;
    logic [W-1:0] special_res;

    always_comb begin
        is_div   = Funct3[2];
        a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
        a_neg    = a_signed && SrcA[W-1];
        b_neg    = b_signed && SrcB[W-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;
        div_zero = is_div && (SrcB == '0);
        div_ovf  = ((Funct3 == 3'b100) || (Funct3 == 3'b110)) &&
                   (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        special  = div_zero || div_ovf;
        // REM/REMU (Funct3[1]) return the dividend on /0 and zero on overflow;
        // DIV/DIVU return all ones on /0 and the dividend (most-negative) on overflow.
        if (div_zero)
            special_res = Funct3[1] ? SrcA : '1;
        else
            special_res = Funct3[1] ? '0 : SrcA;
        accept = Start && !Flush && ((state == S_IDLE) || (state == S_DONE));
    end

    // One iteration of each engine
    logic [W:0]   mul_sum, div_pr, div_diff;
    logic         div_ge;
    logic [W-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_pr   = {hi_q, lo_q[W-1]};
        div_diff = div_pr - {1'b0, opnd_q};
        div_ge   = (div_pr >= {1'b0, opnd_q});
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff[W-1:0] : div_pr[W-1:0];
            step_lo = {lo_q[W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    // Sign fix-up on the finished magnitudes
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s, rem_s, fix_res;

    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_s = neg_q ? -lo_q : lo_q;
        rem_s  = rneg_q ? -hi_q : hi_q;
        if (op_q[2])
            fix_res = op_q[1] ? rem_s : quot_s;
        else
            fix_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_n = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                Busy = 1'b1;
                if (Flush)
                    state_n = S_IDLE;
                else if (count == CW'(W - 1))
                    state_n = S_FIX;
            end
            S_FIX: begin
                Busy    = 1'b1;
                state_n = Flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                Done    = 1'b1;
                state_n = accept ? (special ? S_DONE : S_CALC) : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            count  <= '0;
            Result <= '0;
        end else if (accept) begin
            op_q   <= Funct3;
            opnd_q <= is_div ? b_mag : a_mag;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            count  <= '0;
            if (special)
                Result <= special_res;
        end else if ((state == S_CALC) && !Flush) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            count <= count + CW'(1);
        end else if ((state == S_FIX) && !Flush) begin
            Result <= fix_res;
        end
    end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb/tb_rv_muldiv_unit.sv - self-checking bench for rv_muldiv_unit
module tb_rv_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, Start, Flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        Busy, Done;
    logic [31:0] Result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        bit          poke;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Start in cycle 0; inputs driven at posedge+1, outputs sampled at negedge.
    task automatic run_op(input vec_t v);
        int          done_at;
        int          busy_err;
        logic [31:0] r;
        done_at  = -1;
        busy_err = 0;
        r        = '0;
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = v.f3; SrcA = v.a; SrcB = v.b;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                Start = 1'b0; SrcA = ~v.a; SrcB = v.a ^ v.b; Funct3 = v.f3 ^ 3'b101;
            end
            if (v.poke && c == 5) begin Start = 1'b1; Funct3 = 3'b000; end
            if (v.poke && c == 6) Start = 1'b0;
            @(negedge clk);
            if (Busy !== ((v.lat > 1) && (c <= v.lat - 1))) busy_err++;
            if (Done === 1'b1) begin done_at = c; r = Result; end
        end
        chk({v.name, " done_cycle"}, done_at, v.lat);
        chk({v.name, " busy_profile_errors"}, busy_err, 0);
        chk({v.name, " result"}, r, v.res);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          done_cnt;
        int          d1, d2;
        logic [31:0] prior, r1, r2;

        vecs[0]  = '{"mul_7xm3",      3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1};
        vecs[1]  = '{"mulh_min2",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0};
        vecs[2]  = '{"mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0};
        vecs[3]  = '{"mulhsu_max",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0};
        vecs[4]  = '{"mul_shift",     3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 34, 1'b0};
        vecs[5]  = '{"mulh_m1x2",     3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, 1'b0};
        vecs[6]  = '{"div_m7d2",      3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, 1'b0};
        vecs[7]  = '{"rem_m7d2",      3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, 1'b0};
        vecs[8]  = '{"divu_100d7",    3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0};
        vecs[9]  = '{"remu_100d7",    3'b111, 32'd100,      32'd7,        32'd2,        34, 1'b0};
        vecs[10] = '{"div_20dm3",     3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34, 1'b0};
        vecs[11] = '{"rem_m20d3",     3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 34, 1'b0};
        vecs[12] = '{"divu_nospec",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 1'b0};
        vecs[13] = '{"divu_by0",      3'b101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1,  1'b0};
        vecs[14] = '{"remu_by0",      3'b111, 32'h00001234, 32'h00000000, 32'h00001234, 1,  1'b0};
        vecs[15] = '{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0};
        vecs[16] = '{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b0};
        vecs[17] = '{"rem_by0",       3'b110, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 1,  1'b0};
        vecs[18] = '{"div_by0",       3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1,  1'b0};
        vecs[19] = '{"remu_mod16",    3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 34, 1'b0};

        reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", Busy, 0);
        chk("reset done", Done, 0);
        chk("reset result", Result, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_op(vecs[i]);
        prior = vecs[NV-1].res;

        // DIV flushed in cycle 10, with an ignored Start in cycle 5
        done_cnt = 0;
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = 3'b100; SrcA = 32'hFFFFFFF9; SrcB = 32'd2;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1)  Start = 1'b0;
            if (c == 5)  begin Start = 1'b1; Funct3 = 3'b000; end
            if (c == 6)  Start = 1'b0;
            if (c == 10) Flush = 1'b1;
            if (c == 11) Flush = 1'b0;
            @(negedge clk);
            if (c == 10) chk("flush busy_c10", Busy, 1);
            if (c == 11) chk("flush busy_c11", Busy, 0);
            if (Done === 1'b1) done_cnt++;
        end
        chk("flush no_done", done_cnt, 0);
        chk("flush result_kept", Result, prior);

        // Reset in cycle 20 of a new op
        done_cnt = 0;
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1)  Start = 1'b0;
            if (c == 20) reset = 1'b1;
            if (c == 21) reset = 1'b0;
            @(negedge clk);
            if (c == 20) chk("midreset busy_c20", Busy, 1);
            if (c == 21) begin
                chk("midreset busy_c21", Busy, 0);
                chk("midreset done_c21", Done, 0);
                chk("midreset result_c21", Result, 0);
            end
            if (Done === 1'b1) done_cnt++;
        end
        chk("midreset no_done", done_cnt, 0);

        // Start and Flush together: Start is dropped
        @(posedge clk); #1;
        Start = 1'b1; Flush = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5;
        @(posedge clk); #1;
        Start = 1'b0; Flush = 1'b0;
        @(negedge clk);
        chk("startflush busy", Busy, 0);
        chk("startflush done", Done, 0);

        // Flush during DONE keeps that cycle's Done pulse
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = 3'b111; SrcA = 32'h00001234; SrcB = 32'd0;
        @(posedge clk); #1;
        Start = 1'b0; Flush = 1'b1;
        @(negedge clk);
        chk("doneflush done_c1", Done, 1);
        chk("doneflush result_c1", Result, 32'h00001234);
        @(posedge clk); #1;
        Flush = 1'b0;
        @(negedge clk);
        chk("doneflush done_c2", Done, 0);

        // Back-to-back: second Start in the first op's Done cycle
        d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = 3'b011; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF;
        for (int c = 1; c <= 75; c++) begin
            @(posedge clk); #1;
            if (c == 1)  Start = 1'b0;
            if (c == 34) begin Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5; end
            if (c == 35) begin Start = 1'b0; Funct3 = 3'b100; SrcA = 32'd99; SrcB = 32'd77; end
            @(negedge clk);
            if (c == 35) begin
                chk("b2b done_c35", Done, 0);
                chk("b2b busy_c35", Busy, 1);
            end
            if (Done === 1'b1) begin
                if (d1 < 0) begin d1 = c; r1 = Result; end
                else if (d2 < 0) begin d2 = c; r2 = Result; end
            end
        end
        chk("b2b first_done_cycle", d1, 34);
        chk("b2b first_result", r1, 32'hFFFFFFFE);
        chk("b2b second_done_cycle", d2, 68);
        chk("b2b second_result", r2, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
